// File: rtl/mac_seq.sv
// Sequential fixed-point multiply-accumulate: NIN signed x*w terms per run,
// saturated to DWIDTH bits on completion.
module mac_seq #(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned FRAC   = 24,
   parameter int unsigned NIN    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_valid,
   input  logic [DWIDTH-1:0] i_x,
   input  logic [DWIDTH-1:0] i_w,
   output logic              o_ready,
   output logic              o_busy,
   output logic              o_valid,
   output logic [DWIDTH-1:0] o_sum,
   output logic              o_sat
);

   localparam int unsigned AW = 2 * DWIDTH;
   localparam logic [7:0] LastIdx = 8'(NIN - 1);
   localparam logic signed [AW-1:0] MaxVal = {{(DWIDTH + 1){1'b0}}, {(DWIDTH - 1){1'b1}}};
   localparam logic signed [AW-1:0] MinVal = {{(DWIDTH + 1){1'b1}}, {(DWIDTH - 1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

   state_e                   state_q, state_d;
   logic signed [AW-1:0]     acc_q, acc_d;
   logic [7:0]               cnt_q, cnt_d;
   logic [DWIDTH-1:0]        sum_q, sum_d;
   logic                     sat_q, sat_d;

   logic signed [AW-1:0]     full_prod;
   logic signed [AW-1:0]     prod;
   logic signed [AW-1:0]     acc_sum;
   logic [DWIDTH-1:0]        clip_val;
   logic                     clip_flag;

   assign full_prod = $signed(i_x) * $signed(i_w);
   assign prod      = full_prod >>> FRAC;
   assign acc_sum   = acc_q + prod;

   // Saturation is judged on the sum including the final term, so the result
   // is ready in the same edge that accepts it and appears alongside o_valid.
   always_comb begin
      clip_val  = acc_sum[DWIDTH-1:0];
      clip_flag = 1'b0;
      if (acc_sum > MaxVal) begin
         clip_val  = MaxVal[DWIDTH-1:0];
         clip_flag = 1'b1;
      end else if (acc_sum < MinVal) begin
         clip_val  = MinVal[DWIDTH-1:0];
         clip_flag = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      sat_d   = sat_q;
      case (state_q)
         StIdle: begin
            if (i_start) begin
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StAcc;
            end
         end
         StAcc: begin
            if (i_valid) begin
               acc_d = acc_sum;
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == LastIdx) begin
                  sum_d   = clip_val;
                  sat_d   = clip_flag;
                  state_d = StDone;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         sat_q   <= sat_d;
      end
   end

   assign o_ready = (state_q == StAcc);
   assign o_busy  = (state_q != StIdle);
   assign o_valid = (state_q == StDone);
   assign o_sum   = sum_q;
   assign o_sat   = sat_q;

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Sequential fixed-point multiply-accumulate for one neuron: takes NIN input/weight pairs, one per cycle, and produces one weighted sum.
- Sits directly upstream of the 3-input adder stage.
- Its saturated sum feeds one operand of that adder; bias and the other partial sum supply the rest.
- Data format is signed two's complement, DWIDTH bits with FRAC fractional bits. Default is Q8.24.

Parameters:
- DWIDTH, 32: data width of i_x, i_w and o_sum.
- FRAC, 24: number of fractional bits.
- NIN, 4: number of terms per accumulation. Legal range is 1..255.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous active-low reset.
- i_start, input, 1: starts a new accumulation. Sampled in IDLE only.
- i_valid, input, 1: i_x/i_w pair is valid this cycle.
- i_x, input, DWIDTH: signed input activation.
- i_w, input, DWIDTH: signed weight.
- o_ready, output, 1: high in ACC. A pair is accepted when i_valid && o_ready.
- o_busy, output, 1: high in ACC or DONE.
- o_valid, output, 1: one-cycle pulse when o_sum is updated.
- o_sum, output, DWIDTH: signed saturated sum. Holds until the next o_valid.
- o_sat, output, 1: the last result was clipped. Updated together with o_sum.

Behaviour:
- Reset: when rst_n=0 at a rising edge, everything returns to a known state.
  - State goes to IDLE; accumulator and term counter go to 0.
  - o_ready, o_busy, o_valid, o_sat, o_sum all go to 0.
  - This applies in any state, including mid-accumulation. The partial sum is discarded and no o_valid is produced.
- States:
  - IDLE: o_ready=0, o_busy=0. If i_start=1: clear accumulator, set count=0, go to ACC. i_valid is ignored.
  - ACC: o_ready=1, o_busy=1. On each accepted pair:
    - acc <= acc + prod;
    - count <= count+1.
    - If this pair is number NIN (count==NIN-1), go to DONE. Otherwise stay in ACC.
    - Cycles with i_valid=0 are bubbles: no change to any state.
    - i_start is ignored.
  - DONE: lasts exactly one cycle, then IDLE.
    - Registers o_sum=sat(acc) and o_sat, and asserts o_valid.
    - o_ready=0, o_busy=1.
    - i_start and i_valid are ignored.
- Latency: o_valid is high in the cycle after the clock edge that accepts pair NIN. The earliest next i_start is accepted in the cycle after DONE.
- Arithmetic:
  - prod: i_x * i_w as a full 2*DWIDTH signed product, then arithmetic shift right by FRAC. This truncates toward negative infinity; there is no rounding.
  - acc: signed, 2*DWIDTH bits wide. It never wraps for legal NIN.
  - sat(acc): if acc > 2^(DWIDTH-1)-1, output 2^(DWIDTH-1)-1 and set o_sat=1. If acc < -2^(DWIDTH-1), output -2^(DWIDTH-1) and set o_sat=1. Otherwise output acc[DWIDTH-1:0] and set o_sat=0.
  - Saturation applies only to the final sum. Intermediate overshoot that comes back into range gives an exact result with o_sat=0.
- NIN=1: a single accepted pair goes straight to DONE.

Test Plan:
1. Basic sum, NIN=4.
   - Stimulus: i_start, then 4 back-to-back pairs x=0x01000000 (1.0), w=0x00800000 (0.5).
   - Required: o_valid is a single pulse one cycle after the 4th pair; o_sum=0x02000000 (2.0); o_sat=0; o_busy drops the following cycle.
2. Bubbles.
   - Stimulus: same pairs as scenario 1, with i_valid low for 3 cycles between pairs 2 and 3; also i_valid=1 pulses while in IDLE before i_start.
   - Required: o_sum=0x02000000, o_valid is one cycle after the 4th accepted pair, and the IDLE pairs have no effect.
3. Negative values and truncation.
   - Stimulus A: 4 pairs x=0xFE800000 (-1.5), w=0x02000000 (2.0). Required: o_sum=0xF4000000 (-12.0).
   - Stimulus B: 4 pairs x=0xFFFFFFFF (-1 LSB), w=0x00000001. Required: o_sum=0xFFFFFFFC (floor).
   - Stimulus C: 4 pairs x=1, w=1. Required: o_sum=0.
4. Saturation.
   - Stimulus A: 4 pairs x=w=0x64000000 (100.0). Required: o_sum=0x7FFFFFFF, o_sat=1.
   - Stimulus B: same with x negated. Required: o_sum=0x80000000, o_sat=1.
   - Stimulus C: pairs giving +100, +100, -100, -100. Required: o_sum=0, o_sat=0.
5. Reset mid-operation.
   - Stimulus: after 2 accepted pairs, drive rst_n=0 for 1 cycle.
   - Required: all outputs 0 next cycle; state IDLE; further i_valid ignored.
   - Follow-up: a new i_start plus 4 pairs of 1.0 x 1.0 gives o_sum=0x04000000, with no residue from before reset.
6. Control corner cases.
   - Stimulus: i_start asserted during ACC and DONE.
   - Required: ignored, and the count is unaffected.
   - Stimulus: i_start held high continuously with back-to-back runs.
   - Required: a new run starts in the cycle after DONE; o_sum holds the previous value until the next o_valid.
